// File: rtl/tank_render_ctrl_pkg.sv
// Shared definitions for the tank redraw controller: FSM encodings, sprite geometry and direction codes.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package tank_render_ctrl_pkg;

   // Controller FSM, binary encoded
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ERASE = 2'd1;
   localparam logic [1:0] ST_DRAW  = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   // Background colour used to erase the old sprite
   localparam logic [2:0] BG_COLOUR = 3'b000;

   // Pixels per sprite pass; the external engine raises eng_finish on the last one
   localparam int SPRITE_PIXELS = 60;

   // Direction codes
   localparam logic [1:0] DIR_UP    = 2'd0;
   localparam logic [1:0] DIR_DOWN  = 2'd1;
   localparam logic [1:0] DIR_LEFT  = 2'd2;
   localparam logic [1:0] DIR_RIGHT = 2'd3;

   // Sprite origin plus orientation, as handed to the engine
   typedef struct packed {
      logic [7:0] x;
      logic [6:0] y;
      logic [1:0] dir;
   } pos_t;

endpackage

// File: rtl/tank_render_ctrl_rr_arb2.sv
// Two-way round-robin arbiter: a lone requester wins, a tie goes to the index not granted last.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the grant is consumed.
//
// Ports:
//   req         - request vector, bit i from requester i
//   last_grant  - index granted most recently
//   grant_idx   - winning index (meaningful only when grant_vld)
//   grant_vld   - at least one requester is active
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic       grant_idx,
   output logic       grant_vld
);

   always_comb begin
      grant_vld = |req;
      grant_idx = 1'b0;
      case (req)
         2'b01:   grant_idx = 1'b0;
         2'b10:   grant_idx = 1'b1;
         2'b11:   grant_idx = ~last_grant;
         default: grant_idx = 1'b0;
      endcase
   end

endmodule

// File: rtl/tank_render_ctrl.sv
// Tank redraw controller: grants one of two tanks, erases its old sprite then draws it at the new position.
// Latency: request seen in IDLE cycle t -> ack t+1, erase t+1..t+60, draw t+61..t+120, done t+121.
// Backpressure: level requests are held by the requester until ack; requests seen while busy wait for IDLE.
//
// Ports:
//   clk, resetn           - clock, synchronous active-low reset
//   req[1:0]              - per-tank redraw request
//   pN_old_* / pN_new_*   - previous and target sprite origin/direction of tank N
//   pN_colour             - tank N colour
//   eng_finish            - engine is on its last pixel this cycle
//   eng_xpos/ypos/dir     - sprite origin and direction given to the engine
//   eng_enable            - engine pixel counter advance
//   plot, colour          - VGA write enable and pixel colour
//   ack[1:0]              - one-cycle pulse on the accepted request index
//   done                  - one-cycle pulse when erase+draw completes
//   busy                  - high whenever the FSM is not in IDLE
module tank_render_ctrl
   import tank_render_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       resetn,
   input  logic [1:0] req,
   input  logic [7:0] p0_old_x,
   input  logic [6:0] p0_old_y,
   input  logic [1:0] p0_old_dir,
   input  logic [7:0] p1_old_x,
   input  logic [6:0] p1_old_y,
   input  logic [1:0] p1_old_dir,
   input  logic [7:0] p0_new_x,
   input  logic [6:0] p0_new_y,
   input  logic [1:0] p0_new_dir,
   input  logic [7:0] p1_new_x,
   input  logic [6:0] p1_new_y,
   input  logic [1:0] p1_new_dir,
   input  logic [2:0] p0_colour,
   input  logic [2:0] p1_colour,
   input  logic       eng_finish,
   output logic [7:0] eng_xpos,
   output logic [6:0] eng_ypos,
   output logic [1:0] eng_dir,
   output logic       eng_enable,
   output logic       plot,
   output logic [2:0] colour,
   output logic [1:0] ack,
   output logic       done,
   output logic       busy
);

   logic [1:0] state;
   logic       last_grant;   // index served most recently; 1 after reset so tank 0 wins the first tie
   logic       gnt_q;        // index currently being serviced
   logic [1:0] ack_q;
   pos_t       old_q;
   pos_t       new_q;
   logic [2:0] colour_q;

   logic       arb_idx;
   logic       arb_vld;
   pos_t       sel_old;
   pos_t       sel_new;
   logic [2:0] sel_colour;

   rr_arb2 u_arb (
      .req        (req),
      .last_grant (last_grant),
      .grant_idx  (arb_idx),
      .grant_vld  (arb_vld)
   );

   // Tank inputs only need to be valid in the grant cycle, so select by the arbiter result
   always_comb begin
      if (arb_idx) begin
         sel_old    = '{x: p1_old_x, y: p1_old_y, dir: p1_old_dir};
         sel_new    = '{x: p1_new_x, y: p1_new_y, dir: p1_new_dir};
         sel_colour = p1_colour;
      end else begin
         sel_old    = '{x: p0_old_x, y: p0_old_y, dir: p0_old_dir};
         sel_new    = '{x: p0_new_x, y: p0_new_y, dir: p0_new_dir};
         sel_colour = p0_colour;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state      <= ST_IDLE;
         last_grant <= 1'b1;
         gnt_q      <= 1'b0;
         ack_q      <= 2'b00;
         old_q      <= '0;
         new_q      <= '0;
         colour_q   <= 3'b000;
      end else begin
         // ack is registered so it lands in the first ERASE cycle and lasts one cycle
         ack_q <= 2'b00;
         case (state)
            ST_IDLE: begin
               if (arb_vld) begin
                  gnt_q    <= arb_idx;
                  ack_q    <= arb_idx ? 2'b10 : 2'b01;
                  old_q    <= sel_old;
                  new_q    <= sel_new;
                  colour_q <= sel_colour;
                  state    <= ST_ERASE;
               end
            end
            ST_ERASE: begin
               if (eng_finish) state <= ST_DRAW;
            end
            ST_DRAW: begin
               if (eng_finish) state <= ST_DONE;
            end
            ST_DONE: begin
               last_grant <= gnt_q;
               state      <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_comb begin
      eng_enable = 1'b0;
      plot       = 1'b0;
      colour     = 3'b000;
      eng_xpos   = 8'd0;
      eng_ypos   = 7'd0;
      eng_dir    = 2'd0;
      case (state)
         ST_ERASE: begin
            eng_enable = 1'b1;
            plot       = 1'b1;
            colour     = BG_COLOUR;
            eng_xpos   = old_q.x;
            eng_ypos   = old_q.y;
            eng_dir    = old_q.dir;
         end
         ST_DRAW: begin
            eng_enable = 1'b1;
            plot       = 1'b1;
            colour     = colour_q;
            eng_xpos   = new_q.x;
            eng_ypos   = new_q.y;
            eng_dir    = new_q.dir;
         end
         default: ;
      endcase
   end

   assign ack  = ack_q;
   assign done = (state == ST_DONE);
   assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_tank_render_ctrl.sv
// Bench for tank_render_ctrl with a behavioural 60-pixel sprite engine and a transaction-level reference.
module tb_tank_render_ctrl;
   import tank_render_ctrl_pkg::*;

   typedef struct packed {
      logic [7:0] ox;
      logic [6:0] oy;
      logic [1:0] od;
      logic [7:0] nx;
      logic [6:0] ny;
      logic [1:0] nd;
      logic [2:0] col;
   } stim_t;

   typedef struct {
      logic [1:0] req;
      stim_t      t0;
      stim_t      t1;
      int         exp_g;
   } vec_t;

   logic       clk;
   logic       resetn;
   logic [1:0] req;
   logic       stray;
   stim_t      ts0;
   stim_t      ts1;
   logic       eng_finish;
   logic [7:0] eng_xpos;
   logic [6:0] eng_ypos;
   logic [1:0] eng_dir;
   logic       eng_enable;
   logic       plot;
   logic [2:0] colour;
   logic [1:0] ack;
   logic       done;
   logic       busy;
   logic [5:0] eng_cnt;

   int checks = 0;
   int errors = 0;
   int m_last;          // reference: index served most recently
   vec_t vecs [6];

   tank_render_ctrl dut (
      .clk        (clk),
      .resetn     (resetn),
      .req        (req),
      .p0_old_x   (ts0.ox),
      .p0_old_y   (ts0.oy),
      .p0_old_dir (ts0.od),
      .p1_old_x   (ts1.ox),
      .p1_old_y   (ts1.oy),
      .p1_old_dir (ts1.od),
      .p0_new_x   (ts0.nx),
      .p0_new_y   (ts0.ny),
      .p0_new_dir (ts0.nd),
      .p1_new_x   (ts1.nx),
      .p1_new_y   (ts1.ny),
      .p1_new_dir (ts1.nd),
      .p0_colour  (ts0.col),
      .p1_colour  (ts1.col),
      .eng_finish (eng_finish),
      .eng_xpos   (eng_xpos),
      .eng_ypos   (eng_ypos),
      .eng_dir    (eng_dir),
      .eng_enable (eng_enable),
      .plot       (plot),
      .colour     (colour),
      .ack        (ack),
      .done       (done),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural sprite engine: counts pixels while enabled, flags the last one, wraps to 0
   always_ff @(posedge clk) begin
      if (!resetn)
         eng_cnt <= 6'd0;
      else if (eng_enable)
         eng_cnt <= (eng_cnt == 6'(SPRITE_PIXELS - 1)) ? 6'd0 : eng_cnt + 6'd1;
   end
   assign eng_finish = (eng_cnt == 6'(SPRITE_PIXELS - 1)) || stray;

   function automatic logic [25:0] act_out();
      return {ack, busy, done, plot, eng_enable, colour, eng_xpos, eng_ypos, eng_dir};
   endfunction

   function automatic logic [25:0] exp_out(logic [1:0] a, logic b, logic d, logic p,
                                           logic [2:0] c, logic [7:0] x, logic [6:0] y,
                                           logic [1:0] dr);
      return {a, b, d, p, p, c, x, y, dr};
   endfunction

   function automatic stim_t mk(logic [7:0] ox, logic [6:0] oy, logic [1:0] od,
                                logic [7:0] nx, logic [6:0] ny, logic [1:0] nd,
                                logic [2:0] col);
      stim_t s;
      s.ox = ox; s.oy = oy; s.od = od;
      s.nx = nx; s.ny = ny; s.nd = nd;
      s.col = col;
      return s;
   endfunction

   function automatic stim_t rand_stim();
      return mk(8'($urandom), 7'($urandom), 2'($urandom), 8'($urandom), 7'($urandom),
                2'($urandom), 3'($urandom));
   endfunction

   // Reference arbitration: lone requester wins, a tie goes to the one not served last
   function automatic int model_pick(logic [1:0] r);
      if (r == 2'b01) return 0;
      if (r == 2'b10) return 1;
      return (m_last == 1) ? 0 : 1;
   endfunction

   task automatic chk(input string name, input logic [25:0] act, input logic [25:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Called at a negedge with the DUT in IDLE. Checks the whole erase/draw trace cycle by cycle.
   // abort_at > 0 drops resetn at that cycle and returns; pulse_from/to drive req[1] mid-pass.
   task automatic txn(input logic [1:0] r, input int g, input int abort_at,
                      input int pulse_from, input int pulse_to, input string tag);
      stim_t s;
      logic [25:0] e;
      logic [1:0] oh;
      chk({tag, " pre-idle"}, act_out(), exp_out(2'b00, 0, 0, 0, 3'b000, 8'd0, 7'd0, 2'd0));
      s   = (g == 1) ? ts1 : ts0;
      oh  = (g == 1) ? 2'b10 : 2'b01;
      req = r;
      @(negedge clk);
      for (int k = 1; k <= 2 * SPRITE_PIXELS; k++) begin
         if (k <= SPRITE_PIXELS)
            e = exp_out((k == 1) ? oh : 2'b00, 1, 0, 1, BG_COLOUR, s.ox, s.oy, s.od);
         else
            e = exp_out(2'b00, 1, 0, 1, s.col, s.nx, s.ny, s.nd);
         chk((k <= SPRITE_PIXELS) ? {tag, " erase"} : {tag, " draw"}, act_out(), e);
         if (k == 1) begin
            // requester drops on ack; tank inputs become garbage afterwards
            req[g] = 1'b0;
            ts0 = rand_stim();
            ts1 = rand_stim();
         end
         if (k == pulse_from) req[1] = 1'b1;
         if (k == pulse_to)   req[1] = 1'b0;
         if (k == abort_at) begin
            resetn = 1'b0;
            return;
         end
         @(negedge clk);
      end
      chk({tag, " done"}, act_out(), exp_out(2'b00, 1, 1, 0, 3'b000, 8'd0, 7'd0, 2'd0));
      m_last = g;
      @(negedge clk);
   endtask

   task automatic idle_cycles(input int n, input logic st);
      req = 2'b00;
      for (int i = 0; i < n; i++) begin
         stray = st;
         chk("idle", act_out(), exp_out(2'b00, 0, 0, 0, 3'b000, 8'd0, 7'd0, 2'd0));
         @(negedge clk);
      end
      stray = 1'b0;
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      @(negedge clk);
      chk("reset", act_out(), exp_out(2'b00, 0, 0, 0, 3'b000, 8'd0, 7'd0, 2'd0));
      resetn = 1'b1;
      m_last = 1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0] r;
      int g;
      resetn = 1'b0;
      req    = 2'b00;
      stray  = 1'b0;
      ts0    = '0;
      ts1    = '0;
      m_last = 1;

      // Table: requests applied in order from reset; exp_g follows the round-robin rule by hand
      vecs[0] = '{2'b01, mk(8'd10, 7'd20, DIR_UP, 8'd11, 7'd20, DIR_RIGHT, 3'b100),
                         mk(8'd50, 7'd60, DIR_DOWN, 8'd51, 7'd61, DIR_LEFT, 3'b010), 0};
      vecs[1] = '{2'b11, mk(8'd1, 7'd2, DIR_LEFT, 8'd3, 7'd4, DIR_DOWN, 3'b001),
                         mk(8'd255, 7'd127, DIR_RIGHT, 8'd254, 7'd126, DIR_UP, 3'b111), 1};
      vecs[2] = '{2'b11, mk(8'd0, 7'd0, DIR_UP, 8'd255, 7'd127, DIR_RIGHT, 3'b110),
                         mk(8'd9, 7'd9, DIR_DOWN, 8'd8, 7'd8, DIR_UP, 3'b011), 0};
      vecs[3] = '{2'b10, mk(8'd77, 7'd33, DIR_DOWN, 8'd78, 7'd33, DIR_DOWN, 3'b101),
                         mk(8'd120, 7'd100, DIR_LEFT, 8'd119, 7'd100, DIR_LEFT, 3'b010), 1};
      vecs[4] = '{2'b01, mk(8'd200, 7'd5, DIR_RIGHT, 8'd201, 7'd5, DIR_RIGHT, 3'b111),
                         mk(8'd0, 7'd127, DIR_UP, 8'd0, 7'd126, DIR_UP, 3'b001), 0};
      vecs[5] = '{2'b11, mk(8'd40, 7'd41, DIR_UP, 8'd40, 7'd40, DIR_UP, 3'b100),
                         mk(8'd90, 7'd91, DIR_LEFT, 8'd89, 7'd91, DIR_LEFT, 3'b011), 1};

      repeat (2) @(negedge clk);
      do_reset();

      for (int i = 0; i < 6; i++) begin
         ts0 = vecs[i].t0;
         ts1 = vecs[i].t1;
         txn(vecs[i].req, vecs[i].exp_g, 0, 0, 0, "table");
      end

      // Tie after reset: tank 0, then the still-held tank 1, then tank 0 wins the next tie
      idle_cycles(1, 1'b0);
      do_reset();
      ts0 = rand_stim(); ts1 = rand_stim();
      txn(2'b11, 0, 0, 0, 0, "tie1");
      ts1 = rand_stim();
      txn(req, 1, 0, 0, 0, "tie2");
      ts0 = rand_stim(); ts1 = rand_stim();
      txn(2'b11, 0, 0, 0, 0, "tie3");

      // Stray eng_finish while idle must not start anything
      idle_cycles(4, 1'b1);

      // req1 pulse during tank 0's draw is lost: no ack[1], one done, then idle
      ts0 = rand_stim(); ts1 = rand_stim();
      txn(2'b01, 0, 0, 70, 75, "pulse");
      idle_cycles(3, 1'b0);

      // Reset at draw cycle 30, then a fresh pass from pixel 0
      ts0 = rand_stim(); ts1 = rand_stim();
      txn(2'b10, 1, SPRITE_PIXELS + 30, 0, 0, "abort");
      @(negedge clk);
      chk("post-abort", act_out(), exp_out(2'b00, 0, 0, 0, 3'b000, 8'd0, 7'd0, 2'd0));
      resetn = 1'b1;
      m_last = 1;
      req    = 2'b00;
      ts0 = rand_stim(); ts1 = rand_stim();
      txn(2'b11, 0, 0, 0, 0, "fresh");

      // Randomized traffic against the reference
      for (int i = 0; i < 25; i++) begin
         r   = 2'($urandom_range(1, 3));
         ts0 = rand_stim();
         ts1 = rand_stim();
         g   = model_pick(r);
         txn(r, g, 0, 0, 0, "rand");
         idle_cycles(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
